key_search_ctrl: RTL and testbench

- Sequences the ARC4 decrypt core (init → KSA → PRGA) across a key space to brute-force the secret key.
- For each candidate it launches the core and snoops the core's plaintext-memory writes.
- Accepts the first key whose decrypted message is fully printable; otherwise advances to the next candidate.
- Sits between the top-level cracker and the arc4 core. KEY_START/KEY_STEP allow two instances to split the key space (even/odd).

---
 rtl/key_search_ctrl.sv | 108 ++++++++++
 tb/tb_key_search_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_ctrl.sv
// Brute-force key search sequencer: launches the ARC4 core once per candidate key
// and snoops its plaintext writes, accepting the first key that decrypts to printable text.
module key_search_ctrl #(
  parameter int                KEY_W     = 24,
  parameter logic [KEY_W-1:0]  KEY_START = '0,
  parameter logic [KEY_W-1:0]  KEY_STEP  = KEY_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic             stop,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic             core_en,
  input  logic             core_rdy,
  output logic [KEY_W-1:0] core_key,
  input  logic             pt_wren,
  input  logic [7:0]       pt_addr,
  input  logic [7:0]       pt_wrdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state;
  logic             bad;
  logic             busy_seen;
  logic             stop_pend;
  logic [KEY_W:0]   next_key;
  logic             unprintable;

  // One extra bit so running off the top of the key space is detected, never wrapped.
  assign next_key    = {1'b0, core_key} + {1'b0, KEY_STEP};
  assign unprintable = (pt_wrdata < 8'h20) || (pt_wrdata > 8'h7E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      key_valid <= 1'b0;
      key       <= '0;
      core_en   <= 1'b0;
      core_key  <= KEY_START;
      bad       <= 1'b0;
      busy_seen <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      core_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          stop_pend <= 1'b0;
          if (en) begin
            core_key  <= KEY_START;
            key_valid <= 1'b0;
            rdy       <= 1'b0;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (stop || stop_pend) begin
            rdy   <= 1'b1;
            state <= DONE;
          end else if (core_rdy) begin
            core_en   <= 1'b1;
            bad       <= 1'b0;
            busy_seen <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          // A running core is always allowed to finish; stop is only remembered.
          if (!core_rdy) busy_seen <= 1'b1;
          if (stop) stop_pend <= 1'b1;
          if (pt_wren && (pt_addr != 8'd0) && unprintable) bad <= 1'b1;
          if (core_rdy && busy_seen) state <= CHECK;
        end
        CHECK: begin
          if (!bad) begin
            key       <= core_key;
            key_valid <= 1'b1;
            rdy       <= 1'b1;
            state     <= DONE;
          end else if (stop_pend || stop) begin
            rdy   <= 1'b1;
            state <= DONE;
          end else if (next_key[KEY_W]) begin
            rdy   <= 1'b1;
            state <= DONE;
          end else begin
            core_key <= next_key[KEY_W-1:0];
            state    <= LAUNCH;
          end
        end
        default: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench: a 24-bit searcher and a 4-bit odd-key searcher, each driving
// a behavioural ARC4 core model that writes a key-dependent 8-byte message.
module tb_key_search_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // searcher A: KEY_W=24, start 0, step 1
  logic        en_a = 1'b0, stop_a = 1'b0;
  logic        rdy_a, kv_a, core_en_a;
  logic [23:0] key_a, core_key_a;
  // searcher B: KEY_W=4, start 1, step 2
  logic        en_b = 1'b0, stop_b = 1'b0;
  logic        rdy_b, kv_b, core_en_b;
  logic [3:0]  key_b, core_key_b;

  logic        c_en  [2];
  logic        c_rdy [2];
  logic [23:0] ck    [2];
  logic        pw    [2];
  logic [7:0]  pa    [2];
  logic [7:0]  pd    [2];
  logic        hold  [2];
  int          good  [2];

  assign c_en[0] = core_en_a;
  assign c_en[1] = core_en_b;
  assign ck[0]   = core_key_a;
  assign ck[1]   = {20'd0, core_key_b};

  // Message: addr 0 = 0x00 length byte; good key alternates 0x7E/0x20; others
  // are 'A' except addr 5 which is 0x1F (odd key) or 0x7F (even key).
  function automatic logic [7:0] msg(input logic [23:0] k, input logic [7:0] a, input int g);
    if (a == 8'd0) return 8'h00;
    if (int'(k) == g) return a[0] ? 8'h20 : 8'h7E;
    if (a == 8'd5) return k[0] ? 8'h1F : 8'h7F;
    return 8'h41;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_core
    logic        busy = 1'b0;
    logic        rdy_r = 1'b1;
    logic [7:0]  cnt = 8'd0;
    logic [23:0] lkey = 24'd0;
    assign c_rdy[gi] = rdy_r & ~hold[gi];
    assign pw[gi]    = busy && (cnt <= 8'd8);
    assign pa[gi]    = cnt;
    assign pd[gi]    = msg(lkey, cnt, good[gi]);
    always @(posedge clk) begin
      if (busy) begin
        if (cnt == 8'd12) begin
          busy  <= 1'b0;
          rdy_r <= 1'b1;
        end
        cnt <= cnt + 8'd1;
      end else if (c_rdy[gi] && c_en[gi]) begin
        busy  <= 1'b1;
        rdy_r <= 1'b0;
        cnt   <= 8'd0;
        lkey  <= ck[gi];
      end
    end
  end

  key_search_ctrl #(.KEY_W(24), .KEY_START(24'd0), .KEY_STEP(24'd1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .rdy(rdy_a), .stop(stop_a),
    .key_valid(kv_a), .key(key_a), .core_en(core_en_a), .core_rdy(c_rdy[0]),
    .core_key(core_key_a), .pt_wren(pw[0]), .pt_addr(pa[0]), .pt_wrdata(pd[0])
  );

  key_search_ctrl #(.KEY_W(4), .KEY_START(4'd1), .KEY_STEP(4'd2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .rdy(rdy_b), .stop(stop_b),
    .key_valid(kv_b), .key(key_b), .core_en(core_en_b), .core_rdy(c_rdy[1]),
    .core_key(core_key_b), .pt_wren(pw[1]), .pt_addr(pa[1]), .pt_wrdata(pd[1])
  );

  // launch monitor: one line per core_en pulse
  int          cyc = 0;
  logic [23:0] la[$];
  int          lcyc[$];
  logic [3:0]  lb[$];
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (core_en_a) begin
      la.push_back(core_key_a);
      lcyc.push_back(cyc);
      $display("launch A key=%06h cycle=%0d", core_key_a, cyc);
    end
    if (core_en_b) begin
      lb.push_back(core_key_b);
      $display("launch B key=%0h cycle=%0d", core_key_b, cyc);
    end
  end

  task automatic wait_rdy(input bit which_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((which_b ? rdy_b : rdy_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_launch_a(input logic [23:0] k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (core_en_a === 1'b1 && core_key_a === k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_en_a();
    @(negedge clk); en_a = 1'b1;
    @(negedge clk); en_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy_a, kv_a, core_en_a} !== 3'b100 || key_a !== 24'd0 || core_key_a !== 24'd0) begin
      errors++;
      $display("FAIL reset_a: rdy/kv/en=%b key=%h core_key=%h, want 100 0 0",
               {rdy_a, kv_a, core_en_a}, key_a, core_key_a);
    end
    checks++;
    if (rdy_b !== 1'b1 || kv_b !== 1'b0 || core_key_b !== 4'd1) begin
      errors++;
      $display("FAIL reset_b: rdy=%b kv=%b core_key=%h, want 1 0 1", rdy_b, kv_b, core_key_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_find();
    bit ok, seq_ok;
    good[0] = 3;
    la.delete(); lcyc.delete();
    @(negedge clk); en_a = 1'b1;
    @(negedge clk); en_a = 1'b0;
    checks++;
    if (core_en_a !== 1'b0) begin
      errors++; $display("FAIL latency_early: core_en=%b, want 0", core_en_a);
    end
    @(negedge clk);
    checks++;
    if (core_en_a !== 1'b1 || core_key_a !== 24'd0) begin
      errors++; $display("FAIL latency_first: core_en=%b key=%h, want 1 000000", core_en_a, core_key_a);
    end
    wait_rdy(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: rdy=%b, want 1", rdy_a); end
    seq_ok = (la.size() == 4);
    for (int i = 0; i < la.size() && i < 4; i++) if (la[i] !== 24'(i)) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin errors++; $display("FAIL basic_keys: launches=%0d, want 4 keys 0..3", la.size()); end
    checks++;
    if (lcyc.size() >= 2 && (lcyc[1] - lcyc[0]) != 17) begin
      errors++; $display("FAIL relaunch_gap: %0d cycles, want 17", lcyc[1] - lcyc[0]);
    end
    checks++;
    if (key_a !== 24'h000003 || kv_a !== 1'b1) begin
      errors++; $display("FAIL basic_result: key=%h kv=%b, want 000003 1", key_a, kv_a);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (la.size() != 4 || rdy_a !== 1'b1) begin
      errors++; $display("FAIL basic_no_extra: launches=%0d rdy=%b, want 4 1", la.size(), rdy_a);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    good[0] = 5;
    la.delete();
    pulse_en_a();
    checks++;
    if (kv_a !== 1'b0 || rdy_a !== 1'b0) begin
      errors++; $display("FAIL restart_clear: kv=%b rdy=%b, want 0 0", kv_a, rdy_a);
    end
    wait_rdy(1'b0, ok);
    checks++;
    if (!ok || la.size() != 6 || key_a !== 24'd5 || kv_a !== 1'b1) begin
      errors++; $display("FAIL restart_find: launches=%0d key=%h kv=%b, want 6 000005 1",
                         la.size(), key_a, kv_a);
    end
  endtask

  task automatic test_stop_mid_run(input int g, input bit exp_kv);
    bit ok;
    good[0] = g;
    la.delete();
    pulse_en_a();
    wait_launch_a(24'd2, ok);
    repeat (4) @(negedge clk);
    stop_a = 1'b1;
    @(negedge clk); stop_a = 1'b0;
    wait_rdy(1'b0, ok);
    checks++;
    if (!ok || kv_a !== exp_kv || (exp_kv && key_a !== 24'd2)) begin
      errors++; $display("FAIL stop_result: kv=%b key=%h, want kv=%b key=2 if valid", kv_a, key_a, exp_kv);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (la.size() != 3) begin
      errors++; $display("FAIL stop_launches: %0d, want 3", la.size());
    end
  endtask

  task automatic test_core_not_ready();
    bit ok;
    good[0] = 1;
    la.delete();
    hold[0] = 1'b1;
    pulse_en_a();
    repeat (10) @(negedge clk);
    checks++;
    if (la.size() != 0 || core_en_a !== 1'b0) begin
      errors++; $display("FAIL notready_hold: launches=%0d core_en=%b, want 0 0", la.size(), core_en_a);
    end
    hold[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (core_en_a !== 1'b1 || core_key_a !== 24'd0) begin
      errors++; $display("FAIL notready_release: core_en=%b key=%h, want 1 000000", core_en_a, core_key_a);
    end
    wait_rdy(1'b0, ok);
    checks++;
    if (!ok || key_a !== 24'd1 || kv_a !== 1'b1) begin
      errors++; $display("FAIL notready_find: key=%h kv=%b, want 000001 1", key_a, kv_a);
    end
  endtask

  task automatic test_exhaust_split();
    bit ok, seq_ok;
    good[1] = -1;
    lb.delete();
    @(negedge clk); en_b = 1'b1;
    @(negedge clk); en_b = 1'b0;
    wait_rdy(1'b1, ok);
    seq_ok = (lb.size() == 8);
    for (int i = 0; i < lb.size() && i < 8; i++) if (lb[i] !== 4'(2 * i + 1)) seq_ok = 1'b0;
    checks++;
    if (!ok || !seq_ok) begin
      errors++; $display("FAIL exhaust_keys: launches=%0d, want 8 keys 1,3..15", lb.size());
    end
    repeat (20) @(negedge clk);
    checks++;
    if (lb.size() != 8 || kv_b !== 1'b0 || rdy_b !== 1'b1) begin
      errors++; $display("FAIL exhaust_end: launches=%0d kv=%b rdy=%b, want 8 0 1", lb.size(), kv_b, rdy_b);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    good[0] = -1;
    la.delete();
    pulse_en_a();
    wait_launch_a(24'd1, ok);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (rdy_a !== 1'b1 || kv_a !== 1'b0 || core_en_a !== 1'b0) begin
      errors++; $display("FAIL async_reset: rdy=%b kv=%b core_en=%b, want 1 0 0", rdy_a, kv_a, core_en_a);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    good[0] = 2;
    la.delete();
    pulse_en_a();
    wait_rdy(1'b0, ok);
    checks++;
    if (!ok || la.size() != 3 || la[0] !== 24'd0 || key_a !== 24'd2 || kv_a !== 1'b1) begin
      errors++; $display("FAIL reset_restart: launches=%0d key=%h kv=%b, want 3 from 0, 000002 1",
                         la.size(), key_a, kv_a);
    end
  endtask

  initial begin
    hold[0] = 1'b0; hold[1] = 1'b0;
    good[0] = -1;   good[1] = -1;
    test_reset();
    test_basic_find();
    test_back_to_back();
    test_stop_mid_run(-1, 1'b0);
    test_stop_mid_run(2, 1'b1);
    test_core_not_ready();
    test_exhaust_split();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
